// File: rtl/memory_responder_if.sv
// Request/response bundle between the MDR side and the memory responder.
// master: requester (MDR side); slave: the responder.
interface memory_responder_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic                  MEM_req_valid;
  logic                  MEM_req_write;
  logic [ADDR_WIDTH-1:0] MEM_addr;
  logic [DATA_WIDTH-1:0] MEM_data_from_mdr;
  logic                  MEM_parity_inject;
  logic                  MEM_ready;
  logic                  MEM_resp_valid;
  logic [DATA_WIDTH-1:0] MEM_data_to_mdr;
  logic                  MEM_parity_err;

  modport master (
    output MEM_req_valid, MEM_req_write, MEM_addr, MEM_data_from_mdr, MEM_parity_inject,
    input  MEM_ready, MEM_resp_valid, MEM_data_to_mdr, MEM_parity_err
  );

  modport slave (
    input  MEM_req_valid, MEM_req_write, MEM_addr, MEM_data_from_mdr, MEM_parity_inject,
    output MEM_ready, MEM_resp_valid, MEM_data_to_mdr, MEM_parity_err
  );
endinterface

// File: rtl/memory_responder.sv
// Word-addressed RAM responder: one outstanding request, fixed READ_LATENCY, one-cycle response.
// Optional per-word parity bit enabled by defining MEM_PARITY_EN.
module memory_responder #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                MEM_clock,
  input  logic                MEM_reset,
  memory_responder_if.slave   bus
);
  localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  CntLoad = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  perr_q, perr_d;
  logic                  mem_we;
  logic                  par_err_rd;
  logic [DATA_WIDTH-1:0] mem_rword;
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  assign mem_rword = mem_q[addr_q];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    perr_d       = 1'b0;
    mem_we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Ready is high throughout idle, so valid alone means accept.
        if (bus.MEM_req_valid) begin
          wr_d    = bus.MEM_req_write;
          addr_d  = bus.MEM_addr;
          wdata_d = bus.MEM_data_from_mdr;
          cnt_d   = CntLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_valid_d = 1'b1;
          state_d      = StResp;
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_rword;
            perr_d  = par_err_rd;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge MEM_clock) begin
    if (MEM_reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      perr_q       <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      perr_q       <= perr_d;
      if (mem_we) mem_q[addr_q] <= wdata_q;
    end
  end

`ifdef MEM_PARITY_EN
  logic inj_q, inj_d;
  logic par_q [Depth];

  always_comb begin
    inj_d = inj_q;
    if (state_q == StIdle && bus.MEM_req_valid) inj_d = bus.MEM_parity_inject;
  end

  always_ff @(posedge MEM_clock) begin
    if (MEM_reset) begin
      inj_q <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) par_q[i] <= 1'b0;
    end else begin
      inj_q <= inj_d;
      // Inject flips the stored bit so the next read of this word flags an error.
      if (mem_we) par_q[addr_q] <= (^wdata_q) ^ inj_q;
    end
  end

  assign par_err_rd = par_q[addr_q] ^ (^mem_rword);
`else
  logic unused_inj;
  assign unused_inj = bus.MEM_parity_inject;
  assign par_err_rd = 1'b0;
`endif

  assign bus.MEM_ready       = (state_q == StIdle);
  assign bus.MEM_resp_valid  = resp_valid_q;
  assign bus.MEM_data_to_mdr = rdata_q;
  assign bus.MEM_parity_err  = perr_q;
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: latency, handshake, reset abort, parity hook.
module tb_memory_responder;
`ifdef MEM_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  memory_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) m_if  ();
  memory_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) s1_if ();
  memory_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) s15_if ();

  memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(2)) dut (
    .MEM_clock (clk), .MEM_reset (rst), .bus (m_if.slave)
  );
  memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(1)) dut_l1 (
    .MEM_clock (clk), .MEM_reset (rst), .bus (s1_if.slave)
  );
  memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(15)) dut_l15 (
    .MEM_clock (clk), .MEM_reset (rst), .bus (s15_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request on the latency-2 DUT; returns response data and parity flag.
  task automatic do_req(input string tag, input logic wr, input logic [7:0] addr,
                        input logic [15:0] data, input logic inj,
                        output logic [15:0] rdata, output logic perr);
    int lat;
    for (int i = 0; i < 50 && !m_if.MEM_ready; i++) @(negedge clk);
    check({tag, " ready"}, 32'(m_if.MEM_ready), 32'd1);
    m_if.MEM_req_valid     = 1'b1;
    m_if.MEM_req_write     = wr;
    m_if.MEM_addr          = addr;
    m_if.MEM_data_from_mdr = data;
    m_if.MEM_parity_inject = inj;
    @(posedge clk);
    #1;
    m_if.MEM_req_valid     = 1'b0;
    m_if.MEM_req_write     = ~wr;
    m_if.MEM_addr          = ~addr;
    m_if.MEM_data_from_mdr = ~data;
    m_if.MEM_parity_inject = ~inj;
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (m_if.MEM_resp_valid) lat = i;
    end
    check({tag, " latency"}, 32'(lat), 32'd2);
    rdata = m_if.MEM_data_to_mdr;
    perr  = m_if.MEM_parity_err;
    @(negedge clk);
    check({tag, " pulse_end"}, 32'(m_if.MEM_resp_valid), 32'd0);
    check({tag, " ready_back"}, 32'(m_if.MEM_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] rd;
    logic        pe;
    int          acc_cnt, resp_cnt, last_acc, gap_bad, bad, lat1, lat15;
    bit          acc;

    m_if.MEM_req_valid = 0; m_if.MEM_req_write = 0; m_if.MEM_addr = 0;
    m_if.MEM_data_from_mdr = 0; m_if.MEM_parity_inject = 0;
    s1_if.MEM_req_valid = 0; s1_if.MEM_req_write = 0; s1_if.MEM_addr = 0;
    s1_if.MEM_data_from_mdr = 0; s1_if.MEM_parity_inject = 0;
    s15_if.MEM_req_valid = 0; s15_if.MEM_req_write = 0; s15_if.MEM_addr = 0;
    s15_if.MEM_data_from_mdr = 0; s15_if.MEM_parity_inject = 0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst ready", 32'(m_if.MEM_ready), 32'd1);
    check("rst resp_valid", 32'(m_if.MEM_resp_valid), 32'd0);
    check("rst data", 32'(m_if.MEM_data_to_mdr), 32'h0);
    check("rst perr", 32'(m_if.MEM_parity_err), 32'd0);

    do_req("rd10", 1'b0, 8'h10, 16'h0, 1'b0, rd, pe);
    check("rd10 data", 32'(rd), 32'h0);

    do_req("wr20", 1'b1, 8'h20, 16'h1111, 1'b0, rd, pe);
    do_req("rd20", 1'b0, 8'h20, 16'h0, 1'b0, rd, pe);
    check("rd20 data", 32'(rd), 32'h1111);
    do_req("wr3a", 1'b1, 8'h3A, 16'hBEEF, 1'b0, rd, pe);
    check("wr3a keeps data", 32'(rd), 32'h1111);
    check("wr3a perr", 32'(pe), 32'd0);
    do_req("rd3a", 1'b0, 8'h3A, 16'h0, 1'b0, rd, pe);
    check("rd3a data", 32'(rd), 32'hBEEF);

    // Valid held high: accepts every 4 edges, alternating 0x20 / 0x3A.
    acc_cnt = 0; resp_cnt = 0; last_acc = 0; gap_bad = 0;
    m_if.MEM_req_write = 1'b0;
    m_if.MEM_addr      = 8'h20;
    m_if.MEM_req_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk);
      acc = m_if.MEM_ready;
      if (m_if.MEM_resp_valid) resp_cnt++;
      if (acc) begin
        if (acc_cnt > 0 && i - last_acc != 4) gap_bad++;
        acc_cnt++;
        last_acc = i;
      end
      @(posedge clk);
      #1;
      if (acc) m_if.MEM_addr = (m_if.MEM_addr == 8'h20) ? 8'h3A : 8'h20;
    end
    m_if.MEM_req_valid = 1'b0;
    check("stream accepts", 32'(acc_cnt), 32'd6);
    check("stream responses", 32'(resp_cnt), 32'd6);
    check("stream gap", 32'(gap_bad), 32'd0);
    @(negedge clk);
    check("stream last data", 32'(m_if.MEM_data_to_mdr), 32'hBEEF);

    // Reset one edge after accepting a write: nothing committed, no response.
    m_if.MEM_req_valid = 1'b1; m_if.MEM_req_write = 1'b1;
    m_if.MEM_addr = 8'h05; m_if.MEM_data_from_mdr = 16'h1234;
    @(posedge clk);
    #1 m_if.MEM_req_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_if.MEM_resp_valid) bad++;
    end
    check("abort no resp", 32'(bad), 32'd0);
    check("abort ready", 32'(m_if.MEM_ready), 32'd1);
    check("abort data", 32'(m_if.MEM_data_to_mdr), 32'h0);
    check("abort perr", 32'(m_if.MEM_parity_err), 32'd0);
    do_req("rd05", 1'b0, 8'h05, 16'h0, 1'b0, rd, pe);
    check("rd05 data", 32'(rd), 32'h0);
    do_req("rd3a clr", 1'b0, 8'h3A, 16'h0, 1'b0, rd, pe);
    check("rd3a cleared", 32'(rd), 32'h0);

    // Parity hook: 0x00FF has even parity, so only the injected word flags.
    do_req("wr40 inj", 1'b1, 8'h40, 16'h00FF, 1'b1, rd, pe);
    check("wr40 perr", 32'(pe), 32'd0);
    do_req("rd40", 1'b0, 8'h40, 16'h0, 1'b0, rd, pe);
    check("rd40 data", 32'(rd), 32'h00FF);
    check("rd40 perr", 32'(pe), 32'(ParityEn));
    do_req("wr41", 1'b1, 8'h41, 16'h00FF, 1'b0, rd, pe);
    do_req("rd41", 1'b0, 8'h41, 16'h0, 1'b1, rd, pe);
    check("rd41 perr", 32'(pe), 32'd0);
    check("idle perr", 32'(m_if.MEM_parity_err), 32'd0);

    // Latency 1 and 15 instances, accepted on the same edge.
    check("l1 ready", 32'(s1_if.MEM_ready), 32'd1);
    check("l15 ready", 32'(s15_if.MEM_ready), 32'd1);
    s1_if.MEM_req_valid = 1'b1; s1_if.MEM_addr = 8'h10;
    s15_if.MEM_req_valid = 1'b1; s15_if.MEM_addr = 8'h10;
    @(posedge clk);
    #1 s1_if.MEM_req_valid = 1'b0; s15_if.MEM_req_valid = 1'b0;
    lat1 = -1; lat15 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s1_if.MEM_resp_valid && lat1 < 0) lat1 = i;
      if (s15_if.MEM_resp_valid && lat15 < 0) lat15 = i;
    end
    check("l1 latency", 32'(lat1), 32'd1);
    check("l15 latency", 32'(lat15), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
